// File: rtl/psum_accum.sv
// psum_accum: read-modify-write partial-sum accumulator driving psum_rf, with a valid/ready drain port
module psum_accum #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5,
    parameter int PASS_WIDTH = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_len,
    input  logic [PASS_WIDTH-1:0] i_passes,
    input  logic                  i_psum_valid,
    input  logic [DATA_WIDTH-1:0] i_psum_data,
    output logic                  o_psum_ready,
    output logic                  o_rf_wr_en,
    output logic [ADDR_WIDTH-1:0] o_rf_wr_addr,
    output logic [DATA_WIDTH-1:0] o_rf_wr_data,
    output logic [ADDR_WIDTH-1:0] o_rf_rd_addr,
    input  logic [DATA_WIDTH-1:0] i_rf_rd_data,
    output logic                  o_out_valid,
    output logic [DATA_WIDTH-1:0] o_out_data,
    input  logic                  i_out_ready,
    output logic                  o_busy,
    output logic                  o_done
);
    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;
    localparam logic [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    state_t                state_q;
    logic [ADDR_WIDTH-1:0] addr_q, len_q;
    logic [PASS_WIDTH-1:0] pass_q, passes_q;
    logic                  done_q;
    logic [DATA_WIDTH:0]   sum;
    logic [DATA_WIDTH-1:0] sat_sum;
    logic                  addr_last;
    // one extra bit of headroom exposes overflow as a mismatch of the top two bits
    assign sum = {i_psum_data[DATA_WIDTH-1], i_psum_data} + {i_rf_rd_data[DATA_WIDTH-1], i_rf_rd_data};
    assign sat_sum = (sum[DATA_WIDTH] == sum[DATA_WIDTH-1]) ? sum[DATA_WIDTH-1:0]
                   : (sum[DATA_WIDTH] ? SAT_MIN : SAT_MAX);
    assign addr_last = addr_q == len_q;
    assign o_psum_ready = state_q == ACCUM;
    assign o_rf_wr_en = o_psum_ready & i_psum_valid;
    assign o_rf_wr_addr = o_psum_ready ? addr_q : '0;
    assign o_rf_wr_data = !o_psum_ready ? '0 : (pass_q == '0 ? i_psum_data : sat_sum);
    assign o_rf_rd_addr = addr_q;
    assign o_out_valid = state_q == DRAIN;
    assign o_out_data = o_out_valid ? i_rf_rd_data : '0;
    assign o_busy = state_q != IDLE;
    assign o_done = done_q;
    // tile sequencing: latch geometry on start, walk entries per pass, then drain each entry once
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            len_q    <= '0;
            pass_q   <= '0;
            passes_q <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (i_start) begin
                    state_q  <= ACCUM;
                    len_q    <= i_len;
                    passes_q <= i_passes;
                    addr_q   <= '0;
                    pass_q   <= '0;
                end
                ACCUM: if (i_psum_valid) begin
                    addr_q <= addr_last ? '0 : addr_q + 1'b1;
                    if (addr_last) begin
                        pass_q <= pass_q + 1'b1;
                        if (pass_q == passes_q) state_q <= DRAIN;
                    end
                end
                DRAIN: if (i_out_ready) begin
                    addr_q <= addr_last ? '0 : addr_q + 1'b1;
                    if (addr_last) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_psum_accum.sv
// tb_psum_accum: randomized tiles checked against a per-entry saturating-sum model, with an attached psum_rf model
module tb_psum_accum;
    localparam int DW = 8;
    localparam int AW = 5;
    localparam int PW = 4;
    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 i_start = 1'b0;
    logic [AW-1:0]        i_len = '0;
    logic [PW-1:0]        i_passes = '0;
    logic                 i_psum_valid = 1'b0;
    logic signed [DW-1:0] i_psum_data = '0;
    logic                 o_psum_ready, o_rf_wr_en, o_out_valid, o_busy, o_done;
    logic [AW-1:0]        o_rf_wr_addr, o_rf_rd_addr;
    logic signed [DW-1:0] o_rf_wr_data, i_rf_rd_data, o_out_data;
    logic                 i_out_ready = 1'b1;
    logic                 scramble = 1'b0;
    logic signed [DW-1:0] rf [32];
    int n_chk = 0, n_ok = 0, cyc = 0, acc_cnt = 0, drn_cnt = 0;
    int beats[$];
    int expv[$];
    int exp_q[$];
    logic                 prev_stall = 1'b0;
    logic signed [DW-1:0] prev_out = '0;

    psum_accum #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PASS_WIDTH(PW)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(i_start), .i_len(i_len), .i_passes(i_passes),
        .i_psum_valid(i_psum_valid), .i_psum_data(i_psum_data), .o_psum_ready(o_psum_ready),
        .o_rf_wr_en(o_rf_wr_en), .o_rf_wr_addr(o_rf_wr_addr), .o_rf_wr_data(o_rf_wr_data),
        .o_rf_rd_addr(o_rf_rd_addr), .i_rf_rd_data(i_rf_rd_data), .o_out_valid(o_out_valid),
        .o_out_data(o_out_data), .i_out_ready(i_out_ready), .o_busy(o_busy), .o_done(o_done)
    );

    always #5 clk = ~clk;
    // cycle counter for start-to-done latency
    always @(posedge clk) cyc <= cyc + 1;
    // psum_rf stand-in: combinational read, registered write, optional garbage fill
    always @(posedge clk) begin
        if (scramble) for (int i = 0; i < 32; i++) rf[i] <= DW'($urandom);
        else if (o_rf_wr_en) rf[o_rf_wr_addr] <= o_rf_wr_data;
    end
    assign i_rf_rd_data = rf[o_rf_rd_addr];

    task automatic chk(input string name, input int got, input int want);
        n_chk++;
        if (got == want) n_ok++;
        else $display("FAIL %s: got %0d expected %0d", name, got, want);
    endtask

    function automatic int sat(input int v);
        return v > 127 ? 127 : (v < -128 ? -128 : v);
    endfunction

    // final value of entry j is the pass-by-pass saturating sum of the beats aimed at j
    function automatic void build_model(input int L, input int P);
        expv.delete();
        for (int j = 0; j < L; j++) begin
            int v = beats[j];
            for (int p = 1; p < P; p++) v = sat(v + beats[p*L + j]);
            expv.push_back(v);
        end
    endfunction

    // every-cycle compare of DUT outputs against the expected drain stream and handshake rules
    always @(negedge clk) begin
        if (!rst) begin
            if (i_psum_valid || o_rf_wr_en) chk("wr_en_vs_beat", o_rf_wr_en, i_psum_valid & o_psum_ready);
            if (i_psum_valid && o_psum_ready) acc_cnt++;
            chk("busy", o_busy, o_psum_ready | o_out_valid);
            if (o_out_valid) begin
                if (prev_stall) chk("stall_stable", o_out_data, prev_out);
                if (exp_q.size() == 0) chk("drain_extra", 1, 0);
                else chk("drain_data", o_out_data, exp_q[0]);
                if (i_out_ready) begin
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
                    drn_cnt++;
                end
            end else if (o_out_data != 0) chk("out_data_idle", o_out_data, 0);
            prev_stall = o_out_valid & !i_out_ready;
            prev_out = o_out_data;
        end
    end

    task automatic run_tile(input int L, input int P, input bit rnd, input bit stall3, input bit poke);
        int a0, d0, sc, idx, g, cnt;
        build_model(L, P);
        foreach (expv[k]) exp_q.push_back(expv[k]);
        a0 = acc_cnt;
        d0 = drn_cnt;
        @(posedge clk) #1;
        i_start = 1'b1;
        i_len = AW'(L - 1);
        i_passes = PW'(P - 1);
        sc = cyc;
        @(posedge clk) #1;
        i_start = 1'b0;
        idx = 0;
        g = 0;
        while (idx < L*P && g < 3000) begin
            i_psum_valid = rnd ? ($urandom % 3 != 0) : 1'b1;
            i_psum_data = DW'(beats[idx]);
            if (poke && idx == 1) begin
                i_start = 1'b1;
                i_len = AW'(L);
                i_passes = PW'(P);
            end
            @(negedge clk);
            if (i_psum_valid && o_psum_ready) idx++;
            @(posedge clk) #1;
            i_start = 1'b0;
            g++;
        end
        if (idx < L*P) chk("beat_timeout", idx, L*P);
        i_psum_valid = 1'b0;
        cnt = 0;
        g = 0;
        while (!o_done && g < 3000) begin
            i_out_ready = (stall3 && cnt >= 1 && cnt <= 3) ? 1'b0 : (rnd ? ($urandom % 4 != 0) : 1'b1);
            if (poke && cnt == 0) begin
                i_start = 1'b1;
                i_len = AW'(L);
            end
            @(posedge clk) #1;
            i_start = 1'b0;
            cnt++;
            g++;
        end
        i_out_ready = 1'b1;
        chk("done_seen", o_done, 1);
        if (!rnd && !stall3) chk("tile_cycles", cyc - sc, 1 + L*P + L);
        chk("beats_accepted", acc_cnt - a0, L*P);
        chk("drained", drn_cnt - d0, L);
        chk("busy_at_done", o_busy, 0);
        chk("exp_left", exp_q.size(), 0);
        @(posedge clk) #1;
        chk("done_pulse_end", o_done, 0);
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_busy"}, o_busy, 0);
        chk({tag, "_ready"}, o_psum_ready, 0);
        chk({tag, "_wr_en"}, o_rf_wr_en, 0);
        chk({tag, "_wr_addr"}, o_rf_wr_addr, 0);
        chk({tag, "_wr_data"}, o_rf_wr_data, 0);
        chk({tag, "_rd_addr"}, o_rf_rd_addr, 0);
        chk({tag, "_out_valid"}, o_out_valid, 0);
        chk({tag, "_out_data"}, o_out_data, 0);
        chk({tag, "_done"}, o_done, 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        rst = 1'b0;
        scramble = 1'b1;
        @(posedge clk) #1;
        scramble = 1'b0;
        beats = '{5, -2, 7, 0};
        build_model(4, 1);
        chk("model_sp0", expv[0], 5);
        chk("model_sp1", expv[1], -2);
        run_tile(4, 1, 1'b0, 1'b0, 1'b0);
        beats = '{10, 20, 11, 21, 12, 22};
        build_model(2, 3);
        chk("model_3p0", expv[0], 33);
        chk("model_3p1", expv[1], 63);
        run_tile(2, 3, 1'b0, 1'b0, 1'b0);
        scramble = 1'b1;
        @(posedge clk) #1;
        scramble = 1'b0;
        beats = '{100, 100};
        build_model(1, 2);
        chk("model_satp", expv[0], 127);
        run_tile(1, 2, 1'b0, 1'b0, 1'b0);
        beats = '{-100, -100};
        build_model(1, 2);
        chk("model_satn", expv[0], -128);
        run_tile(1, 2, 1'b0, 1'b0, 1'b0);
        beats = '{127, 127, 127, 127};
        run_tile(1, 4, 1'b0, 1'b0, 1'b0);
        beats.delete();
        for (int i = 0; i < 24; i++) beats.push_back(int'($urandom_range(0, 255)) - 128);
        run_tile(6, 4, 1'b1, 1'b1, 1'b0);
        run_tile(6, 4, 1'b0, 1'b0, 1'b1);
        @(posedge clk) #1;
        i_start = 1'b1;
        i_len = AW'(3);
        i_passes = PW'(2);
        @(posedge clk) #1;
        i_start = 1'b0;
        i_psum_valid = 1'b1;
        i_psum_data = 8'sd9;
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_zero_outputs("midrst");
        exp_q.delete();
        @(posedge clk) #1;
        rst = 1'b0;
        i_psum_valid = 1'b0;
        for (int t = 0; t < 4; t++) begin
            int L = int'($urandom_range(1, 32));
            int P = int'($urandom_range(1, 16));
            beats.delete();
            for (int i = 0; i < L*P; i++) beats.push_back(int'($urandom_range(0, 255)) - 128);
            run_tile(L, P, t[0], t[1], 1'b0);
        end
        beats.delete();
        for (int i = 0; i < 32; i++) beats.push_back(int'($urandom_range(0, 255)) - 128);
        run_tile(32, 1, 1'b0, 1'b0, 1'b0);
        $display("%0d/%0d checks passed", n_ok, n_chk);
        $finish;
    end
endmodule
